// File: rtl/xbar_prog_arbiter_pkg.sv
// Shared definitions for the crossbar program/verify arbiter: state encoding,
// polarity constants and default interval lengths.
package xbar_prog_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DRAIN  = ST_DRAIN,
    S_PULSE  = ST_PULSE,
    S_SETTLE = ST_SETTLE,
    S_VERIFY = ST_VERIFY,
    S_DONE   = ST_DONE
  } state_t;

  localparam logic POL_SET   = 1'b1;
  localparam logic POL_RESET = 1'b0;

  localparam int DEF_GUARD   = 2;
  localparam int DEF_SETTLE  = 3;
  localparam int DEF_VFY_LAT = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xbar_prog_arbiter_if.sv
// Weight-programming request/acknowledge bundle between requester and arbiter.
interface xbar_prog_arbiter_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int PW_WIDTH    = 4,
    parameter int RETRY_WIDTH = 3
);
    // PRG_REQ is a level request held until the one-cycle PRG_ACK (PRG_FAIL valid
    // with it); the PRG_* fields are captured only in the cycle the request is taken.
    logic                   PRG_REQ;
    logic [ADDR_WIDTH-1:0]  PRG_ADDR;
    logic                   PRG_POL;
    logic [PW_WIDTH-1:0]    PRG_PW;
    logic [RETRY_WIDTH-1:0] PRG_RETRY;
    logic                   PRG_ACK;
    logic                   PRG_FAIL;

    modport master (
        output PRG_REQ, PRG_ADDR, PRG_POL, PRG_PW, PRG_RETRY,
        input  PRG_ACK, PRG_FAIL
    );

    modport slave (
        input  PRG_REQ, PRG_ADDR, PRG_POL, PRG_PW, PRG_RETRY,
        output PRG_ACK, PRG_FAIL
    );
endinterface

// File: rtl/xbar_prog_arbiter_timer.sv
// Loadable down-counter with zero flag; times the guard, pulse, settle and
// verify-latency intervals of the arbiter.
module xbar_prog_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Holds at zero rather than wrapping so a late decrement is harmless.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/xbar_prog_arbiter.sv
// Arbitrates the memristor crossbar between inference EN windows and the
// program/verify engine: drain, pulse, settle, verify with bounded retries.
module xbar_prog_arbiter
    import xbar_prog_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int PW_WIDTH    = 4,
    parameter int RETRY_WIDTH = 3,
    parameter int GUARD       = DEF_GUARD,
    parameter int SETTLE      = DEF_SETTLE,
    parameter int VFY_LAT     = DEF_VFY_LAT
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic                  INF_EN,
    xbar_prog_arbiter_if.slave    prg,
    output logic                  BP,
    output logic                  XB_WAKE,
    output logic                  XB_PROG_EN,
    output logic                  XB_POL,
    output logic [ADDR_WIDTH-1:0] XB_ADDR,
    output logic                  XB_VFY_EN,
    input  logic                  XB_VFY_OK,
    output logic                  BUSY,
    output logic                  CONFLICT,
    output state_t                DBG_STATE
);
    localparam int TW = max_int(PW_WIDTH,
                        max_int($clog2(GUARD + 1),
                        max_int($clog2(SETTLE + 1), $clog2(VFY_LAT + 1))));

    state_t                 state;
    logic [PW_WIDTH-1:0]    pw_q;
    logic [RETRY_WIDTH-1:0] retry_q;
    logic [RETRY_WIDTH-1:0] attempts;
    logic                   fail_q;
    logic                   conflict_q;
    logic                   vfy_en_q;

    logic                   t_load;
    logic                   t_dec;
    logic [TW-1:0]          t_val;
    logic                   t_zero;

    xbar_prog_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    // Each state reloads the timer for the interval of the state it hands over to,
    // so the count is already in place on the first cycle of the next state.
    always_comb begin
        t_load = 1'b1;
        t_dec  = 1'b0;
        t_val  = TW'(GUARD - 1);
        case (state)
            S_DRAIN: begin
                if (INF_EN) begin
                    t_val = TW'(GUARD - 1);
                end else if (t_zero) begin
                    t_val = TW'(pw_q);
                end else begin
                    t_load = 1'b0;
                    t_dec  = 1'b1;
                end
            end
            S_PULSE: begin
                if (t_zero) begin
                    t_val = TW'(SETTLE - 1);
                end else begin
                    t_load = 1'b0;
                    t_dec  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (t_zero) begin
                    t_val = TW'(VFY_LAT);
                end else begin
                    t_load = 1'b0;
                    t_dec  = 1'b1;
                end
            end
            S_VERIFY: begin
                if (t_zero) begin
                    t_val = TW'(pw_q);
                end else begin
                    t_load = 1'b0;
                    t_dec  = 1'b1;
                end
            end
            default: begin
                t_val = TW'(GUARD - 1);
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state      <= S_IDLE;
            pw_q       <= '0;
            retry_q    <= '0;
            attempts   <= '0;
            fail_q     <= 1'b0;
            conflict_q <= 1'b0;
            vfy_en_q   <= 1'b0;
            XB_POL     <= POL_RESET;
            XB_ADDR    <= '0;
        end else begin
            vfy_en_q <= 1'b0;
            // Inference touching the array mid-operation is flagged, never aborted:
            // a partially applied memristor pulse would leave the cell undefined.
            if (INF_EN && ((state == S_PULSE) || (state == S_SETTLE) || (state == S_VERIFY))) begin
                conflict_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (prg.PRG_REQ) begin
                        XB_ADDR  <= prg.PRG_ADDR;
                        XB_POL   <= prg.PRG_POL;
                        pw_q     <= prg.PRG_PW;
                        retry_q  <= prg.PRG_RETRY;
                        attempts <= '0;
                        fail_q   <= 1'b0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!INF_EN && t_zero) begin
                        state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (t_zero) begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (t_zero) begin
                        vfy_en_q <= 1'b1;
                        state    <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (t_zero) begin
                        if (XB_VFY_OK) begin
                            fail_q <= 1'b0;
                            state  <= S_DONE;
                        end else if (attempts < retry_q) begin
                            attempts <= attempts + 1'b1;
                            state    <= S_PULSE;
                        end else begin
                            fail_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded from the registered state only, so the async reset clears them at once.
    assign BP           = (state == S_DRAIN) || (state == S_PULSE) ||
                          (state == S_SETTLE) || (state == S_VERIFY);
    assign XB_WAKE      = BP;
    assign XB_PROG_EN   = (state == S_PULSE);
    assign XB_VFY_EN    = vfy_en_q;
    assign BUSY         = (state != S_IDLE);
    assign CONFLICT     = conflict_q;
    assign DBG_STATE    = state;
    assign prg.PRG_ACK  = (state == S_DONE);
    assign prg.PRG_FAIL = (state == S_DONE) && fail_q;
endmodule

// File: tb/tb_xbar_prog_arbiter.sv
// Directed bench for xbar_prog_arbiter: per-operation cycle timings, retries,
// drain, conflict flag and asynchronous reset mid-pulse.
module tb_xbar_prog_arbiter;
    import xbar_prog_arbiter_pkg::*;

    logic        CLK;
    logic        RSTB;
    logic        INF_EN;
    logic        BP;
    logic        XB_WAKE;
    logic        XB_PROG_EN;
    logic        XB_POL;
    logic [7:0]  XB_ADDR;
    logic        XB_VFY_EN;
    logic        XB_VFY_OK;
    logic        BUSY;
    logic        CONFLICT;
    state_t      DBG_STATE;

    int checks = 0;
    int errors = 0;

    // results of the last run_op; cycle 0 is the cycle PRG_REQ is first presented
    int   r_bp_rise, r_pe_first, r_pe_total, r_pe_runs, r_pe_end;
    int   r_drain, r_vfy_first, r_vfy_n, r_ack, r_conf_first;
    logic r_fail, r_bp_ack, r_wake_ack;

    xbar_prog_arbiter_if #(.ADDR_WIDTH(8), .PW_WIDTH(4), .RETRY_WIDTH(3)) prg_if ();

    xbar_prog_arbiter #(
        .ADDR_WIDTH(8), .PW_WIDTH(4), .RETRY_WIDTH(3),
        .GUARD(2), .SETTLE(3), .VFY_LAT(2)
    ) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .INF_EN     (INF_EN),
        .prg        (prg_if),
        .BP         (BP),
        .XB_WAKE    (XB_WAKE),
        .XB_PROG_EN (XB_PROG_EN),
        .XB_POL     (XB_POL),
        .XB_ADDR    (XB_ADDR),
        .XB_VFY_EN  (XB_VFY_EN),
        .XB_VFY_OK  (XB_VFY_OK),
        .BUSY       (BUSY),
        .CONFLICT   (CONFLICT),
        .DBG_STATE  (DBG_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one request and watches the DUT until PRG_ACK or a 120-cycle budget.
    task automatic run_op(input logic [7:0] addr, input logic pol, input logic [3:0] pw,
                          input logic [2:0] retry, input logic [127:0] inf_pat,
                          input logic [7:0] ok_seq);
        logic prev_pe;
        int   nvfy;
        r_bp_rise = -1; r_pe_first = -1; r_pe_total = 0; r_pe_runs = 0; r_pe_end = -1;
        r_drain = 0; r_vfy_first = -1; r_vfy_n = 0; r_ack = -1; r_conf_first = -1;
        r_fail = 1'bx; r_bp_ack = 1'bx; r_wake_ack = 1'bx;
        prev_pe = 1'b0;
        nvfy = 0;
        prg_if.PRG_ADDR  = addr;
        prg_if.PRG_POL   = pol;
        prg_if.PRG_PW    = pw;
        prg_if.PRG_RETRY = retry;
        prg_if.PRG_REQ   = 1'b1;
        INF_EN    = inf_pat[0];
        XB_VFY_OK = 1'b0;
        for (int k = 1; (k < 120) && (r_ack < 0); k++) begin
            tick();
            INF_EN = inf_pat[k];
            if (BP && (r_bp_rise < 0)) r_bp_rise = k;
            if (CONFLICT && (r_conf_first < 0)) r_conf_first = k;
            if (DBG_STATE == S_DRAIN) r_drain++;
            if (XB_PROG_EN) begin
                r_pe_total++;
                if (!prev_pe) r_pe_runs++;
                if (r_pe_first < 0) r_pe_first = k;
            end else if (prev_pe && (r_pe_end < 0)) begin
                r_pe_end = k;
            end
            prev_pe = XB_PROG_EN;
            if (XB_VFY_EN) begin
                if (r_vfy_first < 0) r_vfy_first = k;
                XB_VFY_OK = (nvfy < 8) ? ok_seq[nvfy] : 1'b0;
                nvfy++;
            end
            if (prg_if.PRG_ACK) begin
                r_ack      = k;
                r_fail     = prg_if.PRG_FAIL;
                r_bp_ack   = BP;
                r_wake_ack = XB_WAKE;
                prg_if.PRG_REQ = 1'b0;
            end
        end
        r_vfy_n = nvfy;
        prg_if.PRG_REQ = 1'b0;
        INF_EN = 1'b0;
        XB_VFY_OK = 1'b0;
    endtask

    initial begin
        RSTB = 1'b0;
        INF_EN = 1'b0;
        XB_VFY_OK = 1'b0;
        prg_if.PRG_REQ = 1'b0;
        prg_if.PRG_ADDR = 8'h00;
        prg_if.PRG_POL = 1'b0;
        prg_if.PRG_PW = 4'h0;
        prg_if.PRG_RETRY = 3'h0;
        tick();
        tick();

        // reset state
        chk("rst_bp", BP, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_prog_en", XB_PROG_EN, 0);
        chk("rst_ack", prg_if.PRG_ACK, 0);
        chk("rst_state", DBG_STATE, S_IDLE);
        RSTB = 1'b1;
        tick();

        // clean pass
        run_op(8'h5A, 1'b1, 4'd3, 3'd0, 128'h0, 8'hFF);
        chk("clean_bp_rise", r_bp_rise, 1);
        chk("clean_pe_first", r_pe_first, 3);
        chk("clean_pe_total", r_pe_total, 4);
        chk("clean_vfy_first", r_vfy_first, 10);
        chk("clean_vfy_after_pe_end", r_vfy_first - r_pe_end, 3);
        chk("clean_ack", r_ack, 13);
        chk("clean_fail", r_fail, 0);
        chk("clean_bp_at_ack", r_bp_ack, 0);
        chk("clean_wake_at_ack", r_wake_ack, 0);
        chk("clean_addr", XB_ADDR, 8'h5A);
        chk("clean_pol", XB_POL, 1);
        chk("clean_drain", r_drain, 2);
        tick();
        chk("clean_idle_busy", BUSY, 0);

        // drain: INF_EN high cycles 0..4 and glitch at cycle 6
        run_op(8'h33, 1'b0, 4'd0, 3'd0, 128'h5F, 8'hFF);
        chk("drain_pe_first", r_pe_first, 9);
        chk("drain_pe_total", r_pe_total, 1);
        chk("drain_cycles", r_drain, 8);
        chk("drain_ack", r_ack, 16);
        chk("drain_addr", XB_ADDR, 8'h33);
        chk("drain_pol", XB_POL, 0);
        chk("drain_no_conflict", CONFLICT, 0);
        tick();

        // retry success after two failed verifies
        run_op(8'h11, 1'b1, 4'd1, 3'd3, 128'h0, 8'b0000_0100);
        chk("retry_pe_runs", r_pe_runs, 3);
        chk("retry_pe_total", r_pe_total, 6);
        chk("retry_drain", r_drain, 2);
        chk("retry_vfy_n", r_vfy_n, 3);
        chk("retry_ack", r_ack, 27);
        chk("retry_fail", r_fail, 0);
        tick();

        // retry exhaustion
        run_op(8'h22, 1'b0, 4'd0, 3'd1, 128'h0, 8'h00);
        chk("exh_pe_runs", r_pe_runs, 2);
        chk("exh_ack", r_ack, 17);
        chk("exh_fail", r_fail, 1);
        chk("exh_bp_at_ack", r_bp_ack, 0);
        tick();
        chk("exh_bp_after", BP, 0);

        // INF_EN in IDLE has no effect
        INF_EN = 1'b1;
        tick();
        tick();
        chk("idle_inf_bp", BP, 0);
        chk("idle_inf_conflict", CONFLICT, 0);
        INF_EN = 1'b0;
        tick();

        // conflict in 2nd pulse cycle
        run_op(8'h44, 1'b1, 4'd3, 3'd0, 128'h10, 8'hFF);
        chk("conf_first", r_conf_first, 5);
        chk("conf_pe_total", r_pe_total, 4);
        chk("conf_ack", r_ack, 13);
        chk("conf_fail", r_fail, 0);
        tick();
        tick();
        tick();
        chk("conf_sticky", CONFLICT, 1);

        // reset mid-pulse
        prg_if.PRG_ADDR = 8'h77;
        prg_if.PRG_POL = 1'b1;
        prg_if.PRG_PW = 4'd7;
        prg_if.PRG_RETRY = 3'd0;
        prg_if.PRG_REQ = 1'b1;
        tick();
        prg_if.PRG_REQ = 1'b0;
        tick();
        tick();
        chk("rstp_pulse_on", XB_PROG_EN, 1);
        #2;
        RSTB = 1'b0;
        #1;
        chk("rstp_prog_en", XB_PROG_EN, 0);
        chk("rstp_bp", BP, 0);
        chk("rstp_wake", XB_WAKE, 0);
        chk("rstp_conflict", CONFLICT, 0);
        chk("rstp_addr", XB_ADDR, 0);
        chk("rstp_pol", XB_POL, 0);
        #2;
        RSTB = 1'b1;
        tick();
        chk("rstp_busy_after", BUSY, 0);
        chk("rstp_state_after", DBG_STATE, S_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
